// File: rtl/tlb_op_unit_pkg.sv
// tlb_op_unit_pkg: shared MMU types, TLB geometry and op encodings for the TLB maintenance unit
package tlb_op_unit_pkg;
  localparam int N_TLB_ENTRIES = 32;
  localparam int TLB_IDX_W = $clog2(N_TLB_ENTRIES);
  localparam int TLB_OP_LATENCY = 2;
  typedef enum logic [1:0] {TLBR = 2'd0, TLBWI = 2'd1, TLBWR = 2'd2, TLBP = 2'd3} tlb_op_t;
  typedef logic [TLB_IDX_W-1:0] tlb_index_t;
  typedef struct packed {
    logic [31:0] entry_hi;
    logic [31:0] entry_lo0;
    logic [31:0] entry_lo1;
    logic [31:0] page_mask;
  } tlb_entry_t;
  function automatic logic is_write(tlb_op_t op);
    return op == TLBWI || op == TLBWR;
  endfunction
endpackage

// File: rtl/tlb_op_unit_random_reg.sv
// tlb_random_reg: CP0 Random counter, decrements each cycle and wraps to the top at or below Wired
module tlb_random_reg #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(N)-1:0] wired,
  input  logic                 wired_we,
  output logic [$clog2(N)-1:0] random
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] TOP = W'(N - 1);
  always_ff @(posedge clk)
    random <= (rst || wired_we || random <= wired) ? TOP : random - 1'b1;
endmodule

// File: rtl/tlb_op_unit.sv
// tlb_op_unit: TLBR/TLBWI/TLBWR/TLBP sequencer onto the MMU tlbrw/tlbp ports with Random and CP0 writeback (per-op counters under TLB_OP_PERF_EN)
module tlb_op_unit
  import tlb_op_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
`ifdef TLB_OP_PERF_EN
  output logic [31:0] perf_cnt [4],
  output logic [31:0] perf_tlbp_miss,
`endif
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] cp0_index,
  input  tlb_index_t  cp0_wired,
  input  logic        cp0_wired_we,
  input  logic [31:0] cp0_entry_hi,
  input  tlb_entry_t  cp0_wrentry,
  output tlb_index_t  cp0_random,
  output logic        resp_valid,
  output tlb_op_t     resp_op,
  output tlb_entry_t  resp_rdentry,
  output logic [31:0] resp_index,
  output logic        tlb_updated,
  output tlb_index_t  tlbrw_index,
  output logic        tlbrw_we,
  output tlb_entry_t  tlbrw_wrdata,
  input  tlb_entry_t  tlbrw_rddata,
  output logic [31:0] tlbp_entry_hi,
  input  logic [31:0] tlbp_index
);
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state;
  tlb_op_t op;
  logic unused;
  assign unused = ^cp0_index[31:TLB_IDX_W];
  tlb_random_reg #(.N(N_TLB_ENTRIES)) u_random (
    .clk(clk),
    .rst(rst),
    .wired(cp0_wired),
    .wired_we(cp0_wired_we),
    .random(cp0_random)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      op <= TLBR;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      tlb_updated <= 1'b0;
      tlbrw_we <= 1'b0;
      tlbrw_index <= '0;
      tlbrw_wrdata <= '0;
      tlbp_entry_hi <= '0;
      resp_op <= TLBR;
      resp_rdentry <= '0;
      resp_index <= '0;
    end else begin
      tlbrw_we <= 1'b0;
      resp_valid <= 1'b0;
      tlb_updated <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          state <= ISSUE;
          req_ready <= 1'b0;
          op <= tlb_op_t'(req_op);
          tlbrw_index <= tlb_op_t'(req_op) == TLBWR ? cp0_random : cp0_index[TLB_IDX_W-1:0];
          tlbrw_wrdata <= cp0_wrentry;
          tlbp_entry_hi <= cp0_entry_hi;
          tlbrw_we <= is_write(tlb_op_t'(req_op));
        end
        ISSUE: begin
          state <= DONE;
          resp_valid <= 1'b1;
          tlb_updated <= is_write(op);
          resp_op <= op;
          if (op == TLBR) resp_rdentry <= tlbrw_rddata;
          if (op == TLBP) resp_index <= tlbp_index;
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
`ifdef TLB_OP_PERF_EN
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 4; i++) perf_cnt[i] <= '0;
      perf_tlbp_miss <= '0;
    end else if (resp_valid) begin
      perf_cnt[resp_op] <= perf_cnt[resp_op] + 32'd1;
      if (resp_op == TLBP && resp_index[31]) perf_tlbp_miss <= perf_tlbp_miss + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tlb_op_unit.sv
// tb_tlb_op_unit: table-driven and scoreboard bench for tlb_op_unit
module tb_tlb_op_unit;
  import tlb_op_unit_pkg::*;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [1:0] req_op = 0;
  logic [31:0] cp0_index = 0, cp0_entry_hi = 0;
  tlb_index_t cp0_wired = 0, cp0_random;
  logic cp0_wired_we = 0;
  tlb_entry_t cp0_wrentry = '0, resp_rdentry, tlbrw_wrdata, tlbrw_rddata;
  logic resp_valid, tlb_updated, tlbrw_we;
  tlb_op_t resp_op;
  logic [31:0] resp_index, tlbp_entry_hi, tlbp_index, probe = 0;
  tlb_index_t tlbrw_index;
  int checks = 0, errors = 0, cyc = 0;
  tlb_index_t exp_rand;

  tlb_op_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .cp0_index(cp0_index), .cp0_wired(cp0_wired), .cp0_wired_we(cp0_wired_we),
    .cp0_entry_hi(cp0_entry_hi), .cp0_wrentry(cp0_wrentry), .cp0_random(cp0_random),
    .resp_valid(resp_valid), .resp_op(resp_op), .resp_rdentry(resp_rdentry),
    .resp_index(resp_index), .tlb_updated(tlb_updated), .tlbrw_index(tlbrw_index),
    .tlbrw_we(tlbrw_we), .tlbrw_wrdata(tlbrw_wrdata), .tlbrw_rddata(tlbrw_rddata),
    .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index)
  );

  always #5 clk = ~clk;

  function automatic tlb_entry_t mmu_entry(tlb_index_t i);
    return {32'hE000_0000 | 32'(i), 32'h0100_0000 + 32'(i), 32'h0200_0000 + 32'(i), 32'h0000_6000};
  endfunction

  assign tlbrw_rddata = mmu_entry(tlbrw_index);
  assign tlbp_index = probe;

  // Reference Random model: top value on reset, Wired write, or at/below Wired; else decrement.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    exp_rand <= (rst || cp0_wired_we || exp_rand <= cp0_wired) ? tlb_index_t'(N_TLB_ENTRIES - 1) : exp_rand - 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    tlb_op_t op;
    int cyc;
    logic upd;
    tlb_entry_t rd;
    logic [31:0] idx;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst) chk("random", 128'(cp0_random), 128'(exp_rand));
    if (resp_valid) begin
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", 128'(cyc), 128'(e.cyc));
        chk("resp_op", 128'(resp_op), 128'(e.op));
        chk("tlb_updated", 128'(tlb_updated), 128'(e.upd));
        if (e.op == TLBR) chk("resp_rdentry", resp_rdentry, e.rd);
        if (e.op == TLBP) chk("resp_index", 128'(resp_index), 128'(e.idx));
      end
    end else begin
      if (tlb_updated) chk("updated_without_resp", 1, 0);
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        chk("resp_timeout", 1, 0);
        void'(sb.pop_front());
      end
    end
  end

  typedef struct {
    tlb_op_t op;
    logic [31:0] index;
    tlb_entry_t wr;
    logic [31:0] ehi;
    logic [31:0] probe;
    tlb_index_t exp_idx;
    logic [31:0] exp_resp_index;
  } vec_t;
  vec_t vecs[8];

  task automatic do_op(input vec_t v);
    tlb_index_t eidx;
    exp_t e;
    chk("ready_idle", 128'(req_ready), 1);
    eidx = v.op == TLBWR ? exp_rand : v.exp_idx;
    req_valid = 1;
    req_op = v.op;
    cp0_index = v.index;
    cp0_wrentry = v.wr;
    cp0_entry_hi = v.ehi;
    probe = v.probe;
    e.op = v.op;
    e.cyc = cyc + TLB_OP_LATENCY;
    e.upd = v.op == TLBWI || v.op == TLBWR;
    e.rd = mmu_entry(eidx);
    e.idx = v.exp_resp_index;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    chk("issue_we", 128'(tlbrw_we), 128'(e.upd));
    chk("issue_index", 128'(tlbrw_index), 128'(eidx));
    chk("issue_wrdata", tlbrw_wrdata, v.wr);
    chk("issue_entry_hi", 128'(tlbp_entry_hi), 128'(v.ehi));
    chk("issue_ready", 128'(req_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_we", 128'(tlbrw_we), 0);
    chk("done_ready", 128'(req_ready), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{TLBWI, 32'd5, 128'hA5A5_0001_0000_1111_0000_2222_0000_E000, 32'h0, 32'h0, 5'd5, 32'h0};
    vecs[1] = '{TLBR, 32'd3, 128'h0, 32'h0, 32'h0, 5'd3, 32'h0};
    vecs[2] = '{TLBP, 32'd0, 128'h0, 32'h1234_5000, 32'h8000_0000, 5'd0, 32'h8000_0000};
    vecs[3] = '{TLBP, 32'd7, 128'h0, 32'h0BAD_C0DE, 32'd12, 5'd7, 32'd12};
    vecs[4] = '{TLBWR, 32'd2, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 32'h0, 32'h0, 5'd0, 32'h0};
    vecs[5] = '{TLBWR, 32'd2, 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 32'h0, 32'h0, 5'd0, 32'h0};
    vecs[6] = '{TLBWI, 32'hFFFF_FFE7, 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003, 32'h0, 32'h0, 5'd7, 32'h0};
    vecs[7] = '{TLBR, 32'd31, 128'h0, 32'h0, 32'h0, 5'd31, 32'h0};
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_ready", 128'(req_ready), 1);
    chk("rst_resp_valid", 128'(resp_valid), 0);
    chk("rst_we", 128'(tlbrw_we), 0);
    chk("rst_index", 128'(tlbrw_index), 0);
    chk("rst_wrdata", tlbrw_wrdata, 0);
    chk("rst_entry_hi", 128'(tlbp_entry_hi), 0);
    chk("rst_resp_index", 128'(resp_index), 0);
    chk("rst_rdentry", resp_rdentry, 0);
    for (int k = 0; k < 34; k++) begin
      tlb_index_t want;
      want = tlb_index_t'(31 - k);
      @(negedge clk);
      chk("seq_random", 128'(cp0_random), 128'(want));
    end
    @(posedge clk); #1;
    cp0_wired = 5'd8;
    cp0_wired_we = 1;
    @(posedge clk); #1;
    cp0_wired_we = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      chk("wired_random", 128'(cp0_random), 128'(31 - (k % 24)));
      if (cp0_random < 5'd8) chk("wired_below", 128'(cp0_random), 8);
    end
    @(posedge clk); #1;
    cp0_wired = 5'd0;
    cp0_wired_we = 1;
    @(posedge clk); #1;
    cp0_wired_we = 0;
    for (int i = 0; i < 8; i++) do_op(vecs[i]);
    for (int i = 0; i < 64 && cp0_random != 5'd17; i++) begin
      @(posedge clk); #1;
    end
    chk("random_at_17", 128'(cp0_random), 17);
    do_op('{TLBWR, 32'd1, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 32'h0, 32'h0, 5'd0, 32'h0});
    do_op('{TLBWR, 32'd1, 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210, 32'h0, 32'h0, 5'd0, 32'h0});
    req_valid = 1;
    req_op = TLBWI;
    cp0_index = 32'd9;
    @(posedge clk); #1;
    req_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("abort_issue_we", 128'(tlbrw_we), 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_we", 128'(tlbrw_we), 0);
    chk("abort_ready", 128'(req_ready), 1);
    chk("abort_random", 128'(cp0_random), 31);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_resp", 128'(resp_valid), 0);
      chk("abort_no_we", 128'(tlbrw_we), 0);
      @(negedge clk);
    end
    chk("sb_empty", 128'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
